// File: rtl/addsub_seq_ctrl.sv
// rtl/addsub_seq_ctrl.sv - nibble-serial wide add/subtract controller
//
// Purpose: performs a W = 4*NIBBLES bit unsigned add or subtract by reusing a
// single 4-bit add/sub slice once per clock, least-significant nibble first,
// with the carry/borrow chained between nibbles in a register.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request; accepted only in IDLE or DONE
//   Mode     0 = A+B, 1 = A-B (latched with start)
//   A, B     W-bit unsigned operands (latched with start)
//   busy     high while nibbles are being processed
//   done     one-cycle pulse when S_D/C_B_out are updated
//   S_D      W-bit sum/difference, held until the next completion
//   C_B_out  add: carry out of MSB; subtract: borrow (1 iff A < B)
//   V        (only with ADDSUB_SEQ_OVF_EN) signed two's-complement overflow
//
// Optional feature macro: ADDSUB_SEQ_OVF_EN adds the V output.

module addsub_nibble_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       mode_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] total;

    // Subtract is A + ~B + 1; the +1 arrives through cin on the first nibble.
    assign total  = {1'b0, a_i} + {1'b0, b_i ^ {4{mode_i}}} + {4'b0000, cin_i};
    assign sum_o  = total[3:0];
    assign cout_o = total[4];
endmodule

module addsub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   Mode,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   S_D,
    output logic                   C_B_out
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    output logic                   V
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic           mode_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_q;
    logic [W-1:0]   res_d;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   s_d_q;
    logic           c_b_q;

    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [3:0]     nib_sum;
    logic           nib_cout;
    logic           last_nib;

    addsub_nibble_slice u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .mode_i (mode_q),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
    );

    // Select the current nibble and merge the slice result into the
    // accumulated result so the final nibble is visible in the same edge
    // that moves the full word to S_D.
    always_comb begin
        a_nib    = a_q[{idx_q, 2'b00} +: 4];
        b_nib    = b_q[{idx_q, 2'b00} +: 4];
        res_d    = res_q;
        res_d[{idx_q, 2'b00} +: 4] = nib_sum;
        last_nib = (idx_q == IW'(NIBBLES - 1));
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic v_q;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB sum bit of the last nibble.
    assign msb_cin = a_nib[3] ^ b_nib[3] ^ mode_q ^ nib_sum[3];
    assign V       = v_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_d_q   <= '0;
            c_b_q   <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        mode_q  <= Mode;
                        carry_q <= Mode;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start is deliberately not looked at here.
                    res_q   <= res_d;
                    carry_q <= nib_cout;
                    idx_q   <= idx_q + IW'(1);
                    if (last_nib) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        s_d_q   <= res_d;
                        c_b_q   <= mode_q ? ~nib_cout : nib_cout;
`ifdef ADDSUB_SEQ_OVF_EN
                        v_q     <= msb_cin ^ nib_cout;
`endif
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign S_D     = s_d_q;
    assign C_B_out = c_b_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb/tb_addsub_seq_ctrl.sv - directed self-checking bench for addsub_seq_ctrl
module tb_addsub_seq_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic        Mode;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] S_D;
    logic        C_B_out;
`ifdef ADDSUB_SEQ_OVF_EN
    logic        V;
`endif

    int n_vec;
    int n_err;

    addsub_seq_ctrl #(.NIBBLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Mode    (Mode),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .S_D     (S_D),
        .C_B_out (C_B_out)
`ifdef ADDSUB_SEQ_OVF_EN
        ,
        .V       (V)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives the request across the next posedge and
    // returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic m);
        A     = a;
        B     = b;
        Mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = 16'hDEAD;
        B     = 16'hBEEF;
        Mode  = ~m;
    endtask

    // Counts negedges until done is seen (bounded); returns cycles waited and
    // how many of them had busy high.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input logic [15:0] exp_s, input logic exp_c);
        int lat;
        int bc;
        start_op(a, b, m);
        wait_done(lat, bc);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_busycnt"}, bc, 4);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_s"}, S_D, exp_s);
        check({tag, "_c"}, C_B_out, exp_c);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_hold"}, S_D, exp_s);
    endtask

    initial begin
        int lat;
        int bc;
        logic saw_done;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        Mode  = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", S_D, 0);
        check("rst_c", C_B_out, 0);
`ifdef ADDSUB_SEQ_OVF_EN
        check("rst_v", V, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op("add_3_a",   16'h0003, 16'h000A, 1'b0, 16'h000D, 1'b0);
        run_op("add_ripple",16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("add_ff_ff", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
        run_op("sub_3_9",   16'h0003, 16'h0009, 1'b1, 16'hFFFA, 1'b1);
        run_op("sub_d_a",   16'h000D, 16'h000A, 1'b1, 16'h0003, 1'b0);
        run_op("sub_0_0",   16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0);
        run_op("sub_eq",    16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b0);

        // start during RUN is ignored; S_D keeps the previous result meanwhile
        start_op(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        check("ign_partial_s", S_D, 16'h0000);
        A = 16'hFFFF; B = 16'h0001; Mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("ign_lat", lat, 2);
        check("ign_s", S_D, 16'h2345);
        check("ign_c", C_B_out, 0);

        // back-to-back accept in the DONE cycle
        start_op(16'h0009, 16'h0008, 1'b1);
        check("b2b_done_drop", done, 0);
        wait_done(lat, bc);
        check("b2b_gap", lat + 1, 5);
        check("b2b_s", S_D, 16'h0001);
        check("b2b_c", C_B_out, 0);
        @(negedge clk);

        // reset mid-operation aborts and clears outputs
        start_op(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_s", S_D, 0);
        check("abort_c", C_B_out, 0);
        saw_done = 1'b0;
        repeat (6) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", saw_done, 0);
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

        // rst together with start: request dropped
        A = 16'h0004; B = 16'h0004; Mode = 1'b0; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("rst_start_busy", busy, 0);
        saw_done = 1'b0;
        repeat (6) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("rst_start_idle", saw_done, 0);
        check("rst_start_s", S_D, 0);

`ifdef ADDSUB_SEQ_OVF_EN
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        check("ovf_add_v", V, 1);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0);
        check("ovf_sub_v", V, 1);
        run_op("ovf_none", 16'h0003, 16'h000A, 1'b0, 16'h000D, 1'b0);
        check("ovf_none_v", V, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
